// File: rtl/gpu_command_sequencer.sv
// Byte-stream command decoder that turns SET_ADDRESS / WRITE / FILL commands into framebuffer
// writes, queued through a small FIFO that yields the memory port to VGA scanout.
module gpu_command_sequencer #(
    parameter int unsigned ADDRESS_WIDTH = 22,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                     system_clock,
    input  logic                     reset,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    input  logic                     byte_is_command,
    input  logic                     vga_read_request,
    output logic                     mem_write_enable,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [7:0]               mem_write_data,
    output logic                     busy,
    output logic                     protocol_error,
    output logic                     overflow
);

    localparam int unsigned PtrWidth = $clog2(FIFO_DEPTH);

    typedef enum logic [3:0] {
        StIdle,
        StAddr0,
        StAddr1,
        StAddr2,
        StWrite,
        StFillColor,
        StFillCnt0,
        StFillCnt1,
        StFillRun
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [15:0]              count_q, count_d;
    logic [7:0]               color_q, color_d;
    logic [7:0]               addr_b2_q, addr_b2_d;
    logic [7:0]               addr_b1_q, addr_b1_d;
    logic                     protocol_error_q, protocol_error_d;
    logic                     overflow_q, overflow_d;

    logic [ADDRESS_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [7:0]               fifo_data_q [FIFO_DEPTH];
    logic [PtrWidth-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PtrWidth:0]        fill_q;

    logic       fifo_empty, fifo_full, pop, push_ready, push;
    logic [7:0] push_data;

    assign fifo_empty = (fill_q == '0);
    assign fifo_full  = (fill_q == (PtrWidth + 1)'(FIFO_DEPTH));
    // VGA owns the port outright; the head is popped on the same edge it is presented.
    assign pop        = !fifo_empty && !vga_read_request;
    assign push_ready = !fifo_full || pop;

    assign mem_write_enable = pop;
    assign mem_address      = fifo_addr_q[rd_ptr_q];
    assign mem_write_data   = fifo_data_q[rd_ptr_q];
    assign busy             = !fifo_empty || (state_q == StFillRun);
    assign protocol_error   = protocol_error_q;
    assign overflow         = overflow_q;

    always_comb begin
        state_d          = state_q;
        address_d        = address_q;
        count_d          = count_q;
        color_d          = color_q;
        addr_b2_d        = addr_b2_q;
        addr_b1_d        = addr_b1_q;
        protocol_error_d = protocol_error_q;
        overflow_d       = overflow_q;
        push             = 1'b0;
        push_data        = 8'h00;

        if (byte_valid && byte_is_command) begin
            // Any command aborts the running sequence, including a fill in progress.
            count_d = '0;
            case (byte_data)
                8'h01:   state_d = StAddr0;
                8'h02:   state_d = StWrite;
                8'h03:   state_d = StFillColor;
                8'h04: begin
                    state_d          = StIdle;
                    protocol_error_d = 1'b0;
                    overflow_d       = 1'b0;
                end
                default: begin
                    state_d          = StIdle;
                    protocol_error_d = 1'b1;
                end
            endcase
        end else begin
            case (state_q)
                StIdle: begin
                    if (byte_valid) protocol_error_d = 1'b1;
                end
                StAddr0: begin
                    if (byte_valid) begin
                        addr_b2_d = byte_data;
                        state_d   = StAddr1;
                    end
                end
                StAddr1: begin
                    if (byte_valid) begin
                        addr_b1_d = byte_data;
                        state_d   = StAddr2;
                    end
                end
                StAddr2: begin
                    if (byte_valid) begin
                        address_d = ADDRESS_WIDTH'({addr_b2_q, addr_b1_q, byte_data});
                        state_d   = StIdle;
                    end
                end
                StWrite: begin
                    if (byte_valid) begin
                        if (push_ready) begin
                            push      = 1'b1;
                            push_data = byte_data;
                            address_d = address_q + ADDRESS_WIDTH'(1);
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
                StFillColor: begin
                    if (byte_valid) begin
                        color_d = byte_data;
                        state_d = StFillCnt0;
                    end
                end
                StFillCnt0: begin
                    if (byte_valid) begin
                        count_d[15:8] = byte_data;
                        state_d       = StFillCnt1;
                    end
                end
                StFillCnt1: begin
                    if (byte_valid) begin
                        count_d = {count_q[15:8], byte_data};
                        state_d = ({count_q[15:8], byte_data} == 16'h0000) ? StIdle : StFillRun;
                    end
                end
                StFillRun: begin
                    if (byte_valid) protocol_error_d = 1'b1;
                    // A full FIFO simply stalls the fill; nothing is lost.
                    if (push_ready) begin
                        push      = 1'b1;
                        push_data = color_q;
                        address_d = address_q + ADDRESS_WIDTH'(1);
                        count_d   = count_q - 16'd1;
                        if (count_q == 16'd1) state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            state_q          <= StIdle;
            address_q        <= '0;
            count_q          <= '0;
            color_q          <= '0;
            addr_b2_q        <= '0;
            addr_b1_q        <= '0;
            protocol_error_q <= 1'b0;
            overflow_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            address_q        <= address_d;
            count_q          <= count_d;
            color_q          <= color_d;
            addr_b2_q        <= addr_b2_d;
            addr_b1_q        <= addr_b1_d;
            protocol_error_q <= protocol_error_d;
            overflow_q       <= overflow_d;
        end
    end

    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_addr_q[wr_ptr_q] <= address_q;
                fifo_data_q[wr_ptr_q] <= push_data;
                wr_ptr_q              <= wr_ptr_q + PtrWidth'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            case ({push, pop})
                2'b10:   fill_q <= fill_q + (PtrWidth + 1)'(1);
                2'b01:   fill_q <= fill_q - (PtrWidth + 1)'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_command_sequencer.sv
// Directed bench for gpu_command_sequencer: expected writes are queued as stimulus is driven
// and compared against every mem_write_enable pulse.
module tb_gpu_command_sequencer;

    localparam int unsigned AW = 22;
    localparam int unsigned FD = 4;

    logic          system_clock;
    logic          reset;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_is_command;
    logic          vga_read_request;
    logic          mem_write_enable;
    logic [AW-1:0] mem_address;
    logic [7:0]    mem_write_data;
    logic          busy;
    logic          protocol_error;
    logic          overflow;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_writes = 0;
    int  cycle    = 0;
    int  last_wc  = 0;
    int  prev_wc  = 0;
    int  w0;

    gpu_command_sequencer #(
        .ADDRESS_WIDTH(AW),
        .FIFO_DEPTH   (FD)
    ) dut (
        .system_clock    (system_clock),
        .reset           (reset),
        .byte_valid      (byte_valid),
        .byte_data       (byte_data),
        .byte_is_command (byte_is_command),
        .vga_read_request(vga_read_request),
        .mem_write_enable(mem_write_enable),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .busy            (busy),
        .protocol_error  (protocol_error),
        .overflow        (overflow)
    );

    initial begin
        system_clock = 1'b0;
        forever #5 system_clock = ~system_clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge system_clock) begin
        cycle++;
        if (reset && mem_write_enable) begin
            n_writes++;
            prev_wc = last_wc;
            last_wc = cycle;
            check("vga_priority", {31'd0, vga_read_request}, 32'd0);
            check("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(mem_address), 32'(mon_e.a));
                check("write_data", 32'(mem_write_data), 32'(mon_e.d));
            end
        end
    end

    task automatic send(input logic cmd, input logic [7:0] b);
        byte_valid      = 1'b1;
        byte_is_command = cmd;
        byte_data       = b;
        @(posedge system_clock);
        #1;
        byte_valid      = 1'b0;
        byte_is_command = 1'b0;
        byte_data       = 8'h00;
    endtask

    task automatic set_addr(input logic [23:0] a);
        send(1'b1, 8'h01);
        send(1'b0, a[23:16]);
        send(1'b0, a[15:8]);
        send(1'b0, a[7:0]);
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < 500) begin
            @(posedge system_clock);
            #1;
            k++;
        end
        check("drain_in_time", {31'd0, k < 500}, 32'd1);
        repeat (3) @(posedge system_clock);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset            = 1'b0;
        byte_valid       = 1'b0;
        byte_data        = 8'h00;
        byte_is_command  = 1'b0;
        vga_read_request = 1'b0;
        repeat (3) @(posedge system_clock);
        #1;
        check("rst_we", {31'd0, mem_write_enable}, 32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        check("rst_data", 32'(mem_write_data), 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_perr", {31'd0, protocol_error}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        reset = 1'b1;
        @(posedge system_clock);
        #1;

        // Basic write burst
        set_addr(24'h001234);
        send(1'b1, 8'h02);
        expect_wr(22'h001234, 8'hAA);
        send(1'b0, 8'hAA);
        expect_wr(22'h001235, 8'hBB);
        send(1'b0, 8'hBB);
        drain();
        check("burst_consecutive", 32'(last_wc - prev_wc), 32'd1);
        check("burst_busy_low", {31'd0, busy}, 32'd0);

        // Address wrap
        set_addr(24'h3FFFFE);
        send(1'b1, 8'h02);
        expect_wr(22'h3FFFFE, 8'h11);
        send(1'b0, 8'h11);
        expect_wr(22'h3FFFFF, 8'h22);
        send(1'b0, 8'h22);
        expect_wr(22'h000000, 8'h33);
        send(1'b0, 8'h33);
        drain();

        // Fill held off by VGA
        set_addr(24'h000050);
        vga_read_request = 1'b1;
        w0 = n_writes;
        send(1'b1, 8'h03);
        send(1'b0, 8'h55);
        send(1'b0, 8'h00);
        send(1'b0, 8'h05);
        for (int i = 0; i < 5; i++) expect_wr(22'h000050 + 22'(i), 8'h55);
        repeat (10) begin
            check("fill_hold_busy", {31'd0, busy}, 32'd1);
            @(posedge system_clock);
            #1;
        end
        check("fill_hold_no_write", 32'(n_writes - w0), 32'd0);
        vga_read_request = 1'b0;
        drain();
        check("fill_write_count", 32'(n_writes - w0), 32'd5);
        check("fill_no_ovf", {31'd0, overflow}, 32'd0);

        // Overflow while VGA owns the port
        vga_read_request = 1'b1;
        set_addr(24'h000100);
        send(1'b1, 8'h02);
        w0 = n_writes;
        for (int i = 0; i < FD; i++) begin
            expect_wr(22'h000100 + 22'(i), 8'hD0 + 8'(i));
            send(1'b0, 8'hD0 + 8'(i));
        end
        check("ovf_before", {31'd0, overflow}, 32'd0);
        send(1'b0, 8'hE5);
        check("ovf_after", {31'd0, overflow}, 32'd1);
        send(1'b0, 8'hE6);
        vga_read_request = 1'b0;
        drain();
        check("ovf_write_count", 32'(n_writes - w0), 32'(FD));
        expect_wr(22'h000104, 8'hE0);
        send(1'b0, 8'hE0);
        drain();
        send(1'b1, 8'h04);
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Reset mid-fill discards queued writes
        vga_read_request = 1'b1;
        set_addr(24'h000300);
        send(1'b1, 8'h03);
        send(1'b0, 8'h99);
        send(1'b0, 8'h00);
        send(1'b0, 8'h08);
        repeat (2) @(posedge system_clock);
        #1;
        w0 = n_writes;
        reset = 1'b0;
        #1;
        check("midrst_we", {31'd0, mem_write_enable}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_addr", 32'(mem_address), 32'd0);
        @(posedge system_clock);
        #1;
        reset = 1'b1;
        vga_read_request = 1'b0;
        repeat (10) @(posedge system_clock);
        #1;
        check("midrst_no_write", 32'(n_writes - w0), 32'd0);
        set_addr(24'h000010);
        send(1'b1, 8'h02);
        expect_wr(22'h000010, 8'h5A);
        send(1'b0, 8'h5A);
        drain();

        // Protocol errors
        send(1'b1, 8'h04);
        w0 = n_writes;
        send(1'b0, 8'h33);
        check("perr_idle_data", {31'd0, protocol_error}, 32'd1);
        send(1'b1, 8'h04);
        check("perr_clear1", {31'd0, protocol_error}, 32'd0);
        send(1'b1, 8'h7F);
        check("perr_bad_cmd", {31'd0, protocol_error}, 32'd1);
        check("perr_no_write", 32'(n_writes - w0), 32'd0);
        send(1'b1, 8'h04);
        check("perr_clear2", {31'd0, protocol_error}, 32'd0);

        // Fill aborted by a WRITE command after three pushes
        set_addr(24'h000200);
        w0 = n_writes;
        send(1'b1, 8'h03);
        send(1'b0, 8'h77);
        send(1'b0, 8'h01);
        send(1'b0, 8'h00);
        for (int i = 0; i < 3; i++) expect_wr(22'h000200 + 22'(i), 8'h77);
        repeat (3) @(posedge system_clock);
        #1;
        send(1'b1, 8'h02);
        expect_wr(22'h000203, 8'hC1);
        send(1'b0, 8'hC1);
        expect_wr(22'h000204, 8'hC2);
        send(1'b0, 8'hC2);
        drain();
        check("abort_write_count", 32'(n_writes - w0), 32'd5);
        check("abort_perr", {31'd0, protocol_error}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpu_command_sequencer.md
GPU_COMMAND_SEQUENCER -- requirements
Module: gpu_command_sequencer

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 22: framebuffer byte address width.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two >= 2: depth of the pending-write queue.
REQ-003 system_clock  input  1  sole clock; every flop is rising-edge on it.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 byte_valid  input  1  one-cycle strobe; the bus byte is already synchronized to system_clock.
REQ-006 byte_data  input  8  bus byte; sampled only when byte_valid=1.
REQ-007 byte_is_command  input  1  1 = command byte, 0 = data byte; sampled with byte_valid.
REQ-008 vga_read_request  input  1  VGA scanout needs the framebuffer port this cycle.
REQ-009 mem_write_enable  output  1  one-cycle framebuffer write strobe.
REQ-010 mem_address  output  ADDRESS_WIDTH  write address; valid while mem_write_enable=1.
REQ-011 mem_write_data  output  8  write pixel byte; valid while mem_write_enable=1.
REQ-012 busy  output  1  FIFO non-empty, or state FILL_RUN.
REQ-013 protocol_error  output  1  sticky protocol-violation flag.
REQ-014 overflow  output  1  sticky flag: a write was dropped because the FIFO was full.

Function
REQ-015 Commands: 0x01 SET_ADDRESS + 3 data bytes (address, MSB first, bits above ADDRESS_WIDTH ignored); 0x02 WRITE + any number of pixel bytes; 0x03 FILL + color byte + 2 count bytes (16-bit, MSB first); 0x04 CLEAR_FLAGS (no operands).
REQ-016 States: IDLE, ADDR0, ADDR1, ADDR2, WRITE, FILL_COLOR, FILL_CNT0, FILL_CNT1, FILL_RUN.
REQ-017 A command byte in any state aborts the current sequence, then decodes: 0x01->ADDR0, 0x02->WRITE, 0x03->FILL_COLOR, 0x04->clear both sticky flags and go to IDLE; any other value->IDLE and set protocol_error.
REQ-018 Data bytes: ADDR0->ADDR1->ADDR2 load address bytes 2, 1, 0; the ADDR2 byte commits the address register and returns to IDLE.
REQ-019 A data byte in IDLE, or in FILL_RUN, is dropped and sets protocol_error.
REQ-020 In WRITE, each data byte pushes {address, byte} into the FIFO, increments the address and stays in WRITE.
REQ-021 FILL_COLOR latches the color; FILL_CNT0/FILL_CNT1 latch the count MSB/LSB. After FILL_CNT1: count=0 -> IDLE with no writes; otherwise -> FILL_RUN.
REQ-022 FILL_RUN pushes {address, color} on each cycle the FIFO accepts a push, increments the address, and decrements the count; it goes to IDLE on the cycle the count reaches 0.
REQ-023 Address increments wrap from 2^ADDRESS_WIDTH-1 to 0.
REQ-024 Arbitration: VGA has strict priority. On a cycle with vga_read_request=1, mem_write_enable=0. Otherwise, if the FIFO is non-empty, mem_write_enable=1 with the head entry, and the head is popped on that edge.
REQ-025 Outputs are registered. A push at edge N yields mem_write_enable at the earliest in cycle N+1 (after edge N, before edge N+1).
REQ-026 The FIFO accepts a push when it is not full, or when it is full and a pop occurs on the same edge.
REQ-027 A WRITE-state byte that the FIFO cannot accept is dropped: overflow is set and the address does not advance. FILL_RUN instead stalls (no push, count held) and does not set overflow.
REQ-028 Writes leave the FIFO in push order; no entry is lost or duplicated.
REQ-029 A command byte aborting FILL_RUN discards the remaining count; entries already in the FIFO still drain.

Reset
REQ-030 While reset=0: state=IDLE, address=0, count=0, color=0, FIFO empty, mem_write_enable=0, mem_address=0, mem_write_data=0, busy=0, protocol_error=0, overflow=0.
REQ-031 On release of reset, the first edge with byte_valid=1 is decoded normally.
REQ-032 Reset asserted mid-sequence or mid-fill discards all pending writes immediately.

Verification
REQ-033 Stimulus: cmd 0x01, data 0x00 0x12 0x34, cmd 0x02, data 0xAA 0xBB, vga_read_request=0. Response: writes 0x001234=0xAA, then 0x001235=0xBB, on consecutive cycles; busy drops afterwards.
REQ-034 Stimulus: SET_ADDRESS 0x3FFFFE, WRITE 3 bytes. Response: writes land at 0x3FFFFE, 0x3FFFFF, 0x000000.
REQ-035 Stimulus: FILL color 0x55, count 0x0005, vga_read_request held 1 for 10 cycles then 0. Response: no write during the hold; busy=1 during the hold; then exactly 5 writes of 0x55 at consecutive addresses; overflow stays 0.
REQ-036 Stimulus: vga_read_request=1 constantly, WRITE with FIFO_DEPTH+2 bytes. Response: overflow=1 after byte FIFO_DEPTH+1; after vga_read_request is released, exactly FIFO_DEPTH writes occur.
REQ-037 Stimulus: data byte in IDLE, then cmd 0x7F. Response: protocol_error=1 with no write; cmd 0x04 clears it to 0.
REQ-038 Stimulus: FILL count 0x0100, then cmd 0x02 after 3 pushes. Response: no further fill writes occur once the queued entries have drained; subsequent WRITE data continue from the address after the last fill push.
